// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_types_pkg
//  Purpose  : Shared types for the cache-to-memory path: the machine word,
//             the RAM handshake state and the memory arbiter state encoding.
//  Contents : word_t, ramstate_t, arb_state_t, idx_width()
//  Revision : 1.0  initial release
// ============================================================================
package cpu_types_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   // Encoding is shared with the RAM model, so values are pinned explicitly.
   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   // Prefixed so the names do not collide with the ramstate_t literals.
   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_ACCESS = 1'b1
   } arb_state_t;

   // Width of an index into n items; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Round-robin picker. Returns the first asserted request found
//             when searching upward from i_start, wrapping modulo N.
//             Purely combinational.
//  Ports    : i_req   - request vector, one bit per core
//             i_start - core index where the search begins
//             o_idx   - index of the winning core (0 when none)
//             o_valid - at least one request is asserted
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_start,
   output logic [IW-1:0] o_idx,
   output logic          o_valid
);

   logic [IW-1:0] w_pos;

   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      w_pos   = '0;
      for (int k = 0; k < N; k++) begin
         w_pos = IW'((int'(i_start) + k) % N);
         if (!o_valid && i_req[w_pos]) begin
            o_idx   = w_pos;
            o_valid = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Responder end of the cache-to-memory protocol. Serialises the
//             instruction and data requests of NCPUS cores onto one RAM port,
//             one transaction at a time, and returns per-requester wait/load.
//  Ports    : CLK, nRST (async, active-low)
//             iREN/iaddr  -> iwait/iload         instruction requesters
//             dREN/dWEN/daddr/dstore -> dwait/dload   data requesters
//             ramREN/ramWEN/ramaddr/ramstore     RAM command
//             ramload/ramstate                   RAM response
//             Per-core buses: core c at bits [c*AW +: AW].
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int NCPUS = 2,
   parameter int AW    = 32
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic [NCPUS-1:0]    iREN,
   input  logic [NCPUS*AW-1:0] iaddr,
   output logic [NCPUS-1:0]    iwait,
   output logic [NCPUS*AW-1:0] iload,
   input  logic [NCPUS-1:0]    dREN,
   input  logic [NCPUS-1:0]    dWEN,
   input  logic [NCPUS*AW-1:0] daddr,
   input  logic [NCPUS*AW-1:0] dstore,
   output logic [NCPUS-1:0]    dwait,
   output logic [NCPUS*AW-1:0] dload,
   output logic                ramREN,
   output logic                ramWEN,
   output logic [AW-1:0]       ramaddr,
   output logic [AW-1:0]       ramstore,
   input  logic [AW-1:0]       ramload,
   input  logic [1:0]          ramstate
);

   localparam int IW = idx_width(NCPUS);

   arb_state_t    r_state,  w_next_state;
   logic [IW-1:0] r_core,   w_next_core;
   logic          r_isdata, w_next_isdata;
   logic [IW-1:0] r_rr,     w_next_rr;

   logic [NCPUS-1:0] w_dreq;
   logic [IW-1:0]    w_d_idx, w_i_idx;
   logic             w_d_valid, w_i_valid;
   logic             w_active;

   assign w_dreq = dREN | dWEN;

   // Both classes search from the same shared pointer.
   rr_pick #(.N(NCPUS), .IW(IW)) u_pick_data (
      .i_req   (w_dreq),
      .i_start (r_rr),
      .o_idx   (w_d_idx),
      .o_valid (w_d_valid)
   );

   rr_pick #(.N(NCPUS), .IW(IW)) u_pick_inst (
      .i_req   (iREN),
      .i_start (r_rr),
      .o_idx   (w_i_idx),
      .o_valid (w_i_valid)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state  <= ARB_IDLE;
         r_core   <= '0;
         r_isdata <= 1'b0;
         r_rr     <= '0;
      end else begin
         r_state  <= w_next_state;
         r_core   <= w_next_core;
         r_isdata <= w_next_isdata;
         r_rr     <= w_next_rr;
      end
   end

   always_comb begin
      w_next_state  = r_state;
      w_next_core   = r_core;
      w_next_isdata = r_isdata;
      w_next_rr     = r_rr;
      w_active      = 1'b0;
      iwait         = '1;
      dwait         = '1;
      ramREN        = 1'b0;
      ramWEN        = 1'b0;
      ramaddr       = '0;
      ramstore      = '0;
      // Load buses follow the RAM unconditionally; only wait qualifies them.
      // During reset they are forced to zero.
      for (int c = 0; c < NCPUS; c++) begin
         iload[c*AW +: AW] = nRST ? ramload : '0;
         dload[c*AW +: AW] = nRST ? ramload : '0;
      end

      case (r_state)
         ARB_IDLE: begin
            if (w_d_valid) begin
               w_next_state  = ARB_ACCESS;
               w_next_core   = w_d_idx;
               w_next_isdata = 1'b1;
            end else if (w_i_valid) begin
               w_next_state  = ARB_ACCESS;
               w_next_core   = w_i_idx;
               w_next_isdata = 1'b0;
            end
         end

         ARB_ACCESS: begin
            // RAM is driven live from the granted requester's inputs.
            if (r_isdata) begin
               w_active = dREN[r_core] | dWEN[r_core];
               ramWEN   = dWEN[r_core];
               ramREN   = dREN[r_core] & ~dWEN[r_core];
               ramaddr  = daddr[int'(r_core)*AW +: AW];
               ramstore = dstore[int'(r_core)*AW +: AW];
            end else begin
               w_active = iREN[r_core];
               ramREN   = iREN[r_core];
               ramaddr  = iaddr[int'(r_core)*AW +: AW];
            end

            if (!w_active) begin
               // Requester withdrew: abandon without advancing the pointer.
               ramREN       = 1'b0;
               ramWEN       = 1'b0;
               w_next_state = ARB_IDLE;
            end else if (ramstate == ACCESS) begin
               if (r_isdata) dwait[r_core] = 1'b0;
               else          iwait[r_core] = 1'b0;
               w_next_rr    = (r_core == IW'(NCPUS-1)) ? '0 : r_core + 1'b1;
               w_next_state = ARB_IDLE;
            end
            // FREE, BUSY and ERROR all hold the grant and keep driving.
         end

         default: w_next_state = ARB_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter: directed scenarios plus a
//             randomized run checked against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   localparam int NC = 2;
   localparam int AW = 32;

   logic             CLK = 1'b0;
   logic             nRST;
   logic [NC-1:0]    iREN, iwait, dREN, dWEN, dwait;
   logic [NC*AW-1:0] iaddr, iload, daddr, dstore, dload;
   logic             ramREN, ramWEN;
   logic [AW-1:0]    ramaddr, ramstore, ramload;
   logic [1:0]       ramstate;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 CLK = ~CLK;

   mem_arbiter #(.NCPUS(NC), .AW(AW)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      iREN = '0; dREN = '0; dWEN = '0;
      iaddr = '0; daddr = '0; dstore = '0;
      ramload = '0; ramstate = FREE;
   endtask

   task automatic test_reset();
      clear_inputs();
      iREN = '1; dREN = '1; ramload = 32'hA5A5_A5A5; ramstate = ACCESS;
      nRST = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      n_checks++; if ({dwait, iwait} !== 4'b1111) $display("FAIL rst_wait: got %b want 1111", {dwait, iwait}); else n_pass++;
      n_checks++; if ({ramREN, ramWEN} !== 2'b00) $display("FAIL rst_en: got %b want 00", {ramREN, ramWEN}); else n_pass++;
      n_checks++; if ({ramaddr, ramstore} !== 64'd0) $display("FAIL rst_addr_store: got %h want 0", {ramaddr, ramstore}); else n_pass++;
      n_checks++; if ({iload, dload} !== '0) $display("FAIL rst_loads: got %h want 0", {iload, dload}); else n_pass++;
      clear_inputs();
      @(posedge CLK);
      #1 nRST = 1'b1;
   endtask

   task automatic test_single_fetch();
      step(); iREN[0] = 1'b1; iaddr[0 +: AW] = 32'h40; ramstate = BUSY;
      @(negedge CLK);
      n_checks++; if (ramREN !== 1'b0) $display("FAIL fetch_c0_ren: got %b want 0", ramREN); else n_pass++;
      step();
      @(negedge CLK);
      n_checks++; if ({ramREN, ramaddr} !== {1'b1, 32'h40}) $display("FAIL fetch_c1_cmd: got %b/%h want 1/00000040", ramREN, ramaddr); else n_pass++;
      n_checks++; if (iwait !== 2'b11) $display("FAIL fetch_c1_wait: got %b want 11", iwait); else n_pass++;
      step();
      @(negedge CLK);
      n_checks++; if ({ramREN, iwait} !== 3'b111) $display("FAIL fetch_c2: got ren/iwait %b want 111", {ramREN, iwait}); else n_pass++;
      step(); ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
      @(negedge CLK);
      n_checks++; if ({dwait, iwait} !== 4'b1110) $display("FAIL fetch_c3_wait: got %b want 1110", {dwait, iwait}); else n_pass++;
      n_checks++; if (iload[0 +: AW] !== 32'hDEAD_BEEF) $display("FAIL fetch_c3_load: got %h want deadbeef", iload[0 +: AW]); else n_pass++;
      // Core0 keeps asking; core1 joins. The pointer now favours core1.
      step(); iREN[1] = 1'b1; iaddr[AW +: AW] = 32'h80;
      @(negedge CLK);
      n_checks++; if ({ramREN, dwait, iwait} !== 5'b01111) $display("FAIL fetch_idle_gap: got %b want 01111", {ramREN, dwait, iwait}); else n_pass++;
      step();
      @(negedge CLK);
      n_checks++; if ({ramaddr, iwait} !== {32'h80, 2'b01}) $display("FAIL fetch_rr: got %h/%b want 00000080/01", ramaddr, iwait); else n_pass++;
      step(); clear_inputs();
   endtask

   task automatic test_write();
      step(); dWEN[1] = 1'b1; dREN[1] = 1'b1; daddr[AW +: AW] = 32'h100; dstore[AW +: AW] = 32'h1234; ramstate = FREE;
      @(negedge CLK);
      n_checks++; if (ramWEN !== 1'b0) $display("FAIL wr_idle_wen: got %b want 0", ramWEN); else n_pass++;
      step();
      @(negedge CLK);
      n_checks++; if ({ramWEN, ramREN, ramaddr, ramstore} !== {2'b10, 32'h100, 32'h1234}) $display("FAIL wr_cmd: got %b%b %h %h want 10 00000100 00001234", ramWEN, ramREN, ramaddr, ramstore); else n_pass++;
      n_checks++; if (dwait !== 2'b11) $display("FAIL wr_free_wait: got %b want 11", dwait); else n_pass++;
      step(); ramstate = ACCESS;
      @(negedge CLK);
      n_checks++; if ({dwait, iwait, ramWEN, ramREN} !== 6'b011110) $display("FAIL wr_done: got %b want 011110", {dwait, iwait, ramWEN, ramREN}); else n_pass++;
      step(); clear_inputs();
      @(negedge CLK);
      n_checks++; if ({dwait, ramWEN} !== 3'b110) $display("FAIL wr_after: got %b want 110", {dwait, ramWEN}); else n_pass++;
   endtask

   task automatic test_class_priority();
      step(); iREN[0] = 1'b1; iaddr[0 +: AW] = 32'h200; dREN[0] = 1'b1; daddr[0 +: AW] = 32'h300;
      ramstate = ACCESS; ramload = 32'h1111_2222;
      @(negedge CLK);
      step();
      @(negedge CLK);
      n_checks++; if ({ramaddr, dwait, iwait} !== {32'h300, 4'b1011}) $display("FAIL prio_data_first: got %h/%b want 00000300/1011", ramaddr, {dwait, iwait}); else n_pass++;
      step(); dREN[0] = 1'b0;
      @(negedge CLK);
      n_checks++; if ({ramREN, dwait, iwait} !== 5'b01111) $display("FAIL prio_gap: got %b want 01111", {ramREN, dwait, iwait}); else n_pass++;
      step();
      @(negedge CLK);
      n_checks++; if ({ramaddr, dwait, iwait} !== {32'h200, 4'b1110}) $display("FAIL prio_fetch: got %h/%b want 00000200/1110", ramaddr, {dwait, iwait}); else n_pass++;
      n_checks++; if (iload[0 +: AW] !== 32'h1111_2222) $display("FAIL prio_fetch_load: got %h want 11112222", iload[0 +: AW]); else n_pass++;
      step(); clear_inputs();
   endtask

   task automatic test_back_to_back();
      int order[$];
      int lows;
      nRST = 1'b0;
      step(); nRST = 1'b1;
      dREN = '1; daddr[0 +: AW] = 32'h10; daddr[AW +: AW] = 32'h14; ramstate = ACCESS;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         lows = 0;
         for (int b = 0; b < 2 * NC; b++) if ({dwait, iwait}[b] === 1'b0) lows++;
         n_checks++; if (lows > 1) $display("FAIL b2b_multi_low: cycle %0d got %b want at most one low", i, {dwait, iwait}); else n_pass++;
         for (int c = 0; c < NC; c++) if (dwait[c] === 1'b0) order.push_back(c);
      end
      n_checks++; if (order.size() != 4) $display("FAIL b2b_count: got %0d grants want 4", order.size()); else n_pass++;
      for (int i = 0; i < 4 && i < order.size(); i++) begin
         n_checks++; if (order[i] != i % 2) $display("FAIL b2b_order[%0d]: got core %0d want core %0d", i, order[i], i % 2); else n_pass++;
      end
      step(); clear_inputs();
   endtask

   task automatic test_error_withdraw();
      step(); clear_inputs(); dREN[0] = 1'b1; daddr[0 +: AW] = 32'h44; ramstate = ERROR;
      @(negedge CLK);
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge CLK);
         n_checks++; if ({ramREN, dwait} !== 3'b111) $display("FAIL err_hold[%0d]: got ren/dwait %b want 111", i, {ramREN, dwait}); else n_pass++;
      end
      step(); ramstate = ACCESS;
      @(negedge CLK);
      n_checks++; if (dwait !== 2'b10) $display("FAIL err_done: got %b want 10", dwait); else n_pass++;
      // Pointer now at core1; grant core1 and withdraw it mid-BUSY.
      step(); dREN = 2'b10; daddr[AW +: AW] = 32'h48; ramstate = BUSY;
      @(negedge CLK);
      step();
      @(negedge CLK);
      n_checks++; if ({ramREN, ramaddr} !== {1'b1, 32'h48}) $display("FAIL wd_grant: got %b/%h want 1/00000048", ramREN, ramaddr); else n_pass++;
      step(); dREN[1] = 1'b0;
      @(negedge CLK);
      n_checks++; if ({ramREN, ramWEN, dwait, iwait} !== 6'b001111) $display("FAIL wd_drop: got %b want 001111", {ramREN, ramWEN, dwait, iwait}); else n_pass++;
      step(); ramstate = ACCESS;
      @(negedge CLK);
      n_checks++; if ({ramREN, dwait, iwait} !== 5'b01111) $display("FAIL wd_idle: got %b want 01111", {ramREN, dwait, iwait}); else n_pass++;
      // Pointer must still favour core1.
      step(); dREN = '1; daddr[0 +: AW] = 32'h50;
      @(negedge CLK);
      step();
      @(negedge CLK);
      n_checks++; if ({ramaddr, dwait} !== {32'h48, 2'b01}) $display("FAIL wd_rr_kept: got %h/%b want 00000048/01", ramaddr, dwait); else n_pass++;
      step(); clear_inputs();
   endtask

   task automatic test_reset_midop();
      step(); clear_inputs(); dREN[0] = 1'b1; daddr[0 +: AW] = 32'h60; ramstate = BUSY; ramload = 32'h77;
      @(negedge CLK);
      step();
      @(negedge CLK);
      n_checks++; if (ramREN !== 1'b1) $display("FAIL rmid_active: got %b want 1", ramREN); else n_pass++;
      step();
      #1 nRST = 1'b0;
      #1;
      n_checks++; if ({ramREN, ramWEN, dwait, iwait} !== 6'b001111) $display("FAIL rmid_outputs: got %b want 001111", {ramREN, ramWEN, dwait, iwait}); else n_pass++;
      n_checks++; if (dload !== '0) $display("FAIL rmid_dload: got %h want 0", dload); else n_pass++;
      @(negedge CLK);
      nRST = 1'b1; ramstate = ACCESS;
      @(negedge CLK);
      n_checks++; if ({dwait, iwait} !== 4'b1011) $display("FAIL rmid_retry: got %b want 1011", {dwait, iwait}); else n_pass++;
      n_checks++; if (dload[0 +: AW] !== 32'h77) $display("FAIL rmid_retry_load: got %h want 00000077", dload[0 +: AW]); else n_pass++;
      step(); clear_inputs();
   endtask

   // Randomized traffic. Each requester holds a request until the model says
   // it was served. The model tracks only: idle/busy, who holds the grant,
   // and the pointer, and derives the winner from the arbitration rules.
   task automatic test_random(input int ncyc);
      logic          ip[NC], dp[NC], dw[NC], dr[NC];
      logic [AW-1:0] ia[NC], da[NC], ds[NC];
      logic [AW-1:0] ram_mem[16];
      logic [AW-1:0] exp_mem[16];
      logic [2*NC-1:0] exp_wait;
      logic          exp_ren, exp_wen;
      logic [AW-1:0] exp_addr, exp_load;
      bit            m_busy, m_data, found;
      int            m_core, m_rr, c;

      for (int i = 0; i < 16; i++) begin
         ram_mem[i] = $urandom;
         exp_mem[i] = ram_mem[i];
      end
      for (int i = 0; i < NC; i++) begin
         ip[i] = 1'b0; dp[i] = 1'b0; dw[i] = 1'b0; dr[i] = 1'b0;
         ia[i] = '0; da[i] = '0; ds[i] = '0;
      end
      m_busy = 1'b0; m_data = 1'b0; m_core = 0; m_rr = 0;
      clear_inputs();
      nRST = 1'b0;
      step(); nRST = 1'b1;

      for (int cyc = 0; cyc < ncyc; cyc++) begin
         if (cyc > 0) step();
         for (int i = 0; i < NC; i++) begin
            if (!ip[i] && $urandom_range(2) == 0) begin
               ip[i] = 1'b1;
               ia[i] = {26'd0, 4'($urandom_range(15)), 2'b00};
            end
            if (!dp[i] && $urandom_range(2) == 0) begin
               dp[i] = 1'b1;
               dw[i] = 1'($urandom_range(1));
               dr[i] = dw[i] ? 1'($urandom_range(1)) : 1'b1;
               da[i] = {26'd0, 4'($urandom_range(15)), 2'b00};
               ds[i] = $urandom;
            end
            iREN[i] = ip[i];
            iaddr[i*AW +: AW] = ip[i] ? ia[i] : $urandom;
            dREN[i] = dp[i] & dr[i];
            dWEN[i] = dp[i] & dw[i];
            daddr[i*AW +: AW] = dp[i] ? da[i] : $urandom;
            dstore[i*AW +: AW] = dp[i] ? ds[i] : $urandom;
         end
         if (m_busy && $urandom_range(4) < 2) ramstate = ACCESS;
         else ramstate = 2'($urandom_range(3));
         #1;
         ramload = ramREN ? ram_mem[ramaddr[5:2]] : $urandom;
         @(negedge CLK);

         exp_wait = '1; exp_ren = 1'b0; exp_wen = 1'b0; exp_addr = '0;
         if (m_busy) begin
            if (m_data) begin
               exp_wen = dw[m_core]; exp_ren = ~dw[m_core]; exp_addr = da[m_core];
            end else begin
               exp_ren = 1'b1; exp_addr = ia[m_core];
            end
            if (ramstate == ACCESS) exp_wait[m_data ? NC + m_core : m_core] = 1'b0;
         end
         n_checks++; if ({dwait, iwait} !== exp_wait) $display("FAIL rnd_wait: cycle %0d got %b want %b", cyc, {dwait, iwait}, exp_wait); else n_pass++;
         n_checks++; if ({ramREN, ramWEN} !== {exp_ren, exp_wen}) $display("FAIL rnd_en: cycle %0d got %b want %b", cyc, {ramREN, ramWEN}, {exp_ren, exp_wen}); else n_pass++;
         if (m_busy) begin
            n_checks++; if (ramaddr !== exp_addr) $display("FAIL rnd_addr: cycle %0d got %h want %h", cyc, ramaddr, exp_addr); else n_pass++;
            if (exp_wen) begin
               n_checks++; if (ramstore !== ds[m_core]) $display("FAIL rnd_store: cycle %0d got %h want %h", cyc, ramstore, ds[m_core]); else n_pass++;
            end
         end

         if (m_busy && ramstate == ACCESS) begin
            if (m_data && dw[m_core]) begin
               exp_mem[da[m_core][5:2]] = ds[m_core];
            end else if (m_data) begin
               exp_load = exp_mem[da[m_core][5:2]];
               n_checks++; if (dload[m_core*AW +: AW] !== exp_load) $display("FAIL rnd_dload: cycle %0d core %0d got %h want %h", cyc, m_core, dload[m_core*AW +: AW], exp_load); else n_pass++;
            end else begin
               exp_load = exp_mem[ia[m_core][5:2]];
               n_checks++; if (iload[m_core*AW +: AW] !== exp_load) $display("FAIL rnd_iload: cycle %0d core %0d got %h want %h", cyc, m_core, iload[m_core*AW +: AW], exp_load); else n_pass++;
            end
            if (m_data) dp[m_core] = 1'b0; else ip[m_core] = 1'b0;
            m_rr   = (m_core + 1) % NC;
            m_busy = 1'b0;
         end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < NC; k++) begin
               c = (m_rr + k) % NC;
               if (!found && dp[c]) begin found = 1'b1; m_data = 1'b1; m_core = c; end
            end
            for (int k = 0; k < NC; k++) begin
               c = (m_rr + k) % NC;
               if (!found && ip[c]) begin found = 1'b1; m_data = 1'b0; m_core = c; end
            end
            m_busy = found;
         end

         if (ramWEN && ramstate == ACCESS) ram_mem[ramaddr[5:2]] = ramstore;
      end
      step(); clear_inputs();
   endtask

   initial begin
      nRST = 1'b0;
      clear_inputs();
      test_reset();
      test_single_fetch();
      test_write();
      test_class_priority();
      test_back_to_back();
      test_error_withdraw();
      test_reset_midop();
      test_random(3000);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
